// File: rtl/alu_serial_rx.sv
// alu_serial_rx
//   Serial frame receiver for the ALU input link. Deserializes 11-bit packets
//   (start 0, type, 8 payload bits MSB first, stop 1) from sin, assembles
//   operand B then A from eight DATA packets, and checks the CTL packet's
//   CRC-4 (x^4+x+1 over {B, A, 1'b1, OP}) and opcode. Every completed or
//   aborted frame produces a one-cycle rx_done strobe with error flags.
//
//   Optional feature macro: ALU_RX_TIMEOUT_EN
//     When defined, a partial frame left idle for TIMEOUT_CYCLES cycles is
//     aborted with err_data. When undefined, a partial frame waits forever.
//
//   Ports:
//     clk       in   clock, sin sampled on the rising edge
//     rst       in   synchronous active-high reset
//     sin       in   serial input, idles high
//     rx_done   out  one-cycle strobe, frame accepted or aborted
//     a, b      out  32-bit operands, valid on an error-free rx_done
//     op        out  3-bit opcode, valid on an error-free rx_done
//     err_data  out  wrong DATA count, framing error or timeout
//     err_crc   out  CRC mismatch
//     err_op    out  unsupported opcode
module alu_serial_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic        rx_done,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [2:0]  op,
  output logic        err_data,
  output logic        err_crc,
  output logic        err_op
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_STOP,
    ST_DONE,
    ST_WAIT_HIGH
  } state_t;

  state_t      state;
  logic [3:0]  bit_cnt;
  logic        is_ctl;
  logic [7:0]  pkt;
  logic [63:0] data_sr;
  logic [3:0]  count;
  logic [3:0]  crc;
  logic [3:0]  crc_final;

`ifdef ALU_RX_TIMEOUT_EN
  localparam int unsigned IW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IW-1:0] idle_cnt;
`endif

  function automatic logic [3:0] crc_step(input logic [3:0] c, input logic d);
    logic fb;
    fb = c[3] ^ d;
    return {c[2:0], 1'b0} ^ {2'b00, fb, fb};
  endfunction

  function automatic logic [3:0] crc_byte(input logic [3:0] c, input logic [7:0] d);
    logic [3:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++) r = crc_step(r, d[7-i]);
    return r;
  endfunction

  // DATA bytes are folded into crc as each packet completes; the CTL tail
  // {1'b1, OP} is folded in here from the received CTL payload.
  always_comb begin
    crc_final = crc_step(crc, 1'b1);
    for (int unsigned i = 0; i < 3; i++) crc_final = crc_step(crc_final, pkt[6-i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      is_ctl   <= 1'b0;
      pkt      <= '0;
      data_sr  <= '0;
      count    <= '0;
      crc      <= '0;
      rx_done  <= 1'b0;
      a        <= '0;
      b        <= '0;
      op       <= '0;
      err_data <= 1'b0;
      err_crc  <= 1'b0;
      err_op   <= 1'b0;
`ifdef ALU_RX_TIMEOUT_EN
      idle_cnt <= '0;
`endif
    end else begin
      rx_done  <= 1'b0;
      err_data <= 1'b0;
      err_crc  <= 1'b0;
      err_op   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (!sin) begin
            state   <= ST_SHIFT;
            bit_cnt <= '0;
`ifdef ALU_RX_TIMEOUT_EN
            idle_cnt <= '0;
`endif
          end
`ifdef ALU_RX_TIMEOUT_EN
          else if (count != 4'd0) begin
            if (idle_cnt == IW'(TIMEOUT_CYCLES - 1)) begin
              rx_done  <= 1'b1;
              err_data <= 1'b1;
              count    <= '0;
              crc      <= '0;
              data_sr  <= '0;
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
`endif
        end

        ST_SHIFT: begin
          if (bit_cnt == 4'd0) is_ctl <= sin;
          else                 pkt    <= {pkt[6:0], sin};
          if (bit_cnt == 4'd8) state   <= ST_STOP;
          else                 bit_cnt <= bit_cnt + 1'b1;
        end

        ST_STOP: begin
          if (!sin) begin
            rx_done  <= 1'b1;
            err_data <= 1'b1;
            count    <= '0;
            crc      <= '0;
            data_sr  <= '0;
            state    <= ST_WAIT_HIGH;
          end else if (is_ctl) begin
            state <= ST_DONE;
          end else begin
            if (count < 4'd8) begin
              data_sr <= {data_sr[55:0], pkt};
              crc     <= crc_byte(crc, pkt);
            end
            if (count < 4'd9) count <= count + 1'b1;
            state <= ST_IDLE;
          end
        end

        ST_DONE: begin
          rx_done <= 1'b1;
          if (count != 4'd8) begin
            err_data <= 1'b1;
          end else if (crc_final != pkt[3:0]) begin
            err_crc <= 1'b1;
          end else if (pkt[5]) begin
            // valid opcodes are 000, 001, 100, 101: OP[1] must be clear
            err_op <= 1'b1;
          end else begin
            b  <= data_sr[63:32];
            a  <= data_sr[31:0];
            op <= pkt[6:4];
          end
          count   <= '0;
          crc     <= '0;
          data_sr <= '0;
          // the next start bit may already be on the line this cycle
          if (!sin) begin
            state   <= ST_SHIFT;
            bit_cnt <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_WAIT_HIGH: begin
          if (sin) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_rx.sv
module tb_alu_serial_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        sin;
  logic        rx_done;
  logic [31:0] a, b;
  logic [2:0]  op;
  logic        err_data, err_crc, err_op;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc = 0;
  int unsigned stray = 0;
  int unsigned last_stop = 0;

  logic [31:0] ea = '0, eb = '0;
  logic [2:0]  eop = '0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        ed, ec, eo;
    int unsigned cyc;
  } res_t;
  res_t q[$];

  alu_serial_rx #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .sin(sin), .rx_done(rx_done),
    .a(a), .b(b), .op(op),
    .err_data(err_data), .err_crc(err_crc), .err_op(err_op)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_done) begin
      res_t r;
      r.a = a; r.b = b; r.op = op;
      r.ed = err_data; r.ec = err_crc; r.eo = err_op;
      r.cyc = cyc;
      q.push_back(r);
    end else if (err_data || err_crc || err_op) begin
      stray++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // CRC as polynomial remainder of {B, A, 1, OP} * x^4 mod x^4+x+1
  function automatic logic [3:0] crc_model(input logic [31:0] bv, input logic [31:0] av,
                                           input logic [2:0] o);
    logic [71:0] r;
    r = {bv, av, 1'b1, o, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  task automatic send_bit(input logic v);
    sin = v;
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic typ, input logic [7:0] d, input logic stop_bit);
    send_bit(1'b0);
    send_bit(typ);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(stop_bit);
    last_stop = cyc;
    sin = 1'b1;
  endtask

  task automatic send_frame(input logic [31:0] bv, input logic [31:0] av, input logic [2:0] o,
                            input logic [3:0] c, input int ndata);
    logic [63:0] v;
    v = {bv, av};
    for (int k = 0; k < ndata; k++)
      send_pkt(1'b0, (k < 8) ? v[63-8*k -: 8] : 8'hA5, 1'b1);
    send_pkt(1'b1, {1'b0, o, c}, 1'b1);
  endtask

  task automatic expect_frame(input string tag, input int unsigned stop_c, input int unsigned lat,
                              input logic ed, input logic ec, input logic eo);
    res_t r;
    if (q.size() == 0) begin
      check({tag, "_strobe"}, 32'd0, 32'd1);
    end else begin
      r = q.pop_front();
      check({tag, "_lat"},      r.cyc - stop_c, lat);
      check({tag, "_err_data"}, 32'(r.ed), 32'(ed));
      check({tag, "_err_crc"},  32'(r.ec), 32'(ec));
      check({tag, "_err_op"},   32'(r.eo), 32'(eo));
      check({tag, "_a"},        r.a, ea);
      check({tag, "_b"},        r.b, eb);
      check({tag, "_op"},       32'(r.op), 32'(eop));
    end
  endtask

  task automatic idle(input int n);
    sin = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned s1, s2;
    sin = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_done", 32'(rx_done), 32'd0);
    check("rst_a", a, 32'd0);
    check("rst_b", b, 32'd0);
    check("rst_op", 32'(op), 32'd0);
    check("rst_flags", 32'({err_data, err_crc, err_op}), 32'd0);
    rst = 1'b0;
    idle(2);

    // zero operands, hand CRC B
    send_frame(32'd0, 32'd0, 3'b000, 4'hB, 8);
    idle(3);
    expect_frame("zero_ok", last_stop, 1, 0, 0, 0);

    // B=1, A=2, OP=100
    send_frame(32'd1, 32'd2, 3'b100, crc_model(32'd1, 32'd2, 3'b100), 8);
    idle(3);
    eb = 32'd1; ea = 32'd2; eop = 3'b100;
    expect_frame("b1a2", last_stop, 1, 0, 0, 0);

    // bad CRC: outputs hold
    send_frame(32'd0, 32'd0, 3'b000, 4'hA, 8);
    idle(3);
    expect_frame("bad_crc", last_stop, 1, 0, 1, 0);

    // 7 DATA packets
    send_frame(32'h11111111, 32'h22222222, 3'b000, 4'h0, 7);
    idle(3);
    expect_frame("seven_data", last_stop, 1, 1, 0, 0);

    // 10 DATA packets: count saturates, still wrong
    send_frame(32'h0, 32'h0, 3'b000, 4'hB, 10);
    idle(3);
    expect_frame("ten_data", last_stop, 1, 1, 0, 0);

    // invalid opcode, hand CRC D
    send_frame(32'd0, 32'd0, 3'b010, 4'hD, 8);
    idle(3);
    expect_frame("bad_op", last_stop, 1, 0, 0, 1);

    // back-to-back frames, next start bit lands on the DONE cycle
    send_frame(32'hDEADBEEF, 32'h12345678, 3'b101, crc_model(32'hDEADBEEF, 32'h12345678, 3'b101), 8);
    s1 = last_stop;
    send_frame(32'hA5A5A5A5, 32'h0F0F0F0F, 3'b001, crc_model(32'hA5A5A5A5, 32'h0F0F0F0F, 3'b001), 8);
    s2 = last_stop;
    idle(3);
    eb = 32'hDEADBEEF; ea = 32'h12345678; eop = 3'b101;
    expect_frame("b2b_first", s1, 1, 0, 0, 0);
    eb = 32'hA5A5A5A5; ea = 32'h0F0F0F0F; eop = 3'b001;
    expect_frame("b2b_second", s2, 1, 0, 0, 0);

    // reset in the middle of the 5th DATA packet
    for (int k = 0; k < 4; k++) send_pkt(1'b0, 8'h3C, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    check("midrst_no_strobe", q.size(), 32'd0);
    check("midrst_a", a, 32'd0);
    ea = '0; eb = '0; eop = '0;
    idle(2);
    send_frame(32'h000000FF, 32'hFF000000, 3'b001, crc_model(32'h000000FF, 32'hFF000000, 3'b001), 8);
    idle(3);
    eb = 32'h000000FF; ea = 32'hFF000000; eop = 3'b001;
    expect_frame("post_rst", last_stop, 1, 0, 0, 0);

    // framing error after two DATA packets, line held low, then resync
    send_pkt(1'b0, 8'h81, 1'b1);
    send_pkt(1'b0, 8'h42, 1'b1);
    send_pkt(1'b0, 8'h55, 1'b0);
    sin = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(2);
    expect_frame("framing", last_stop, 0, 1, 0, 0);
    send_frame(32'hCAFEF00D, 32'h00C0FFEE, 3'b000, crc_model(32'hCAFEF00D, 32'h00C0FFEE, 3'b000), 8);
    idle(3);
    eb = 32'hCAFEF00D; ea = 32'h00C0FFEE; eop = 3'b000;
    expect_frame("resync", last_stop, 1, 0, 0, 0);
    check("no_extra_strobes", q.size(), 32'd0);

    // partial frame left idle
    for (int k = 0; k < 3; k++) send_pkt(1'b0, 8'h77, 1'b1);
    s1 = last_stop;
    idle(150);
`ifdef ALU_RX_TIMEOUT_EN
    expect_frame("timeout", s1, 64, 1, 0, 0);
    check("timeout_single", q.size(), 32'd0);
`else
    check("no_timeout", q.size(), 32'd0);
`endif
    check("flags_only_with_strobe", stray, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
